// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: constants and types shared by the MEM stage and its bus FSM.
// The build option MEM_MISALIGN_TRAP_EN (see mem_stage.sv) needs nothing extra here.
package mem_stage_pkg;

    // NOPE ALU opcode; the EX stage uses the same value.
    localparam logic [3:0] ALU_OP_NOPE  = 4'd9;

    // Longest wait for dmem_ready before the access is abandoned.
    localparam logic [7:0] TIMEOUT      = 8'd16;
    localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic        zero;
        logic [4:0]  rd;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        memwrite;
        logic        regwrite;
        logic        uncond_jmp;
        logic [31:0] rs2_data;
        logic [31:0] pc;
    } ex_mem_t;

    // A bubble carries no valid bit and no control bits.
    localparam ex_mem_t EX_MEM_BUBBLE = '0;

endpackage

// File: rtl/mem_bus_fsm.sv
// mem_bus_fsm: data-memory request/ready handshake with a bounded wait.
// The timeout completion abandons the access and latches a sticky bus error.
module mem_bus_fsm
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_access,
    input  logic i_ready,
    output logic o_req,
    output logic o_stall,
    output logic o_timeout,
    output logic o_bus_error
);

    bus_state_t r_state;
    bus_state_t w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_timeout;
    logic       r_bus_error;

    // State and wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: zero-wait completes in IDLE, otherwise count in WAIT until ready or timeout.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_access && !i_ready) begin
                    w_state_next = WAIT;
                    w_cnt_next   = 8'd0;
                end
            end
            WAIT: begin
                if (i_ready) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_timeout    = i_access;
                    w_state_next = IDLE;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sticky bus error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_error <= 1'b0;
        end else if (w_timeout) begin
            r_bus_error <= 1'b1;
        end
    end

    assign o_req       = i_access;
    assign o_stall     = i_access & ~i_ready & ~w_timeout;
    assign o_timeout   = w_timeout;
    assign o_bus_error = r_bus_error;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory access, branch resolution, MEM/WB register.
// Build option MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued and pulse MEM_misaligned.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_ALU_result,
    input  logic        EX_zero,
    input  logic [4:0]  EX_rd,
    input  logic        EX_branch,
    input  logic        EX_memread,
    input  logic        EX_memtoreg,
    input  logic        EX_memwrite,
    input  logic        EX_regwrite,
    input  logic        EX_unconditional_jmp,
    input  logic [31:0] EX_rs2_data,
    input  logic [31:0] EX_pc,
    input  logic        EX_stall,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memread,
    output logic        EX_MEM_memtoreg,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_stall,
    output logic        MEM_flush,
    output logic [31:0] MEM_redirect_pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        MEM_misaligned,
`endif
    output logic        MEM_bus_error
);

    ex_mem_t     r_ex_mem;
    ex_mem_t     w_ex_capture;
    logic [4:0]  r_wb_rd;
    logic        r_wb_regwrite;
    logic [31:0] r_wb_result;
    logic        w_memop;
    logic        w_misaligned;
    logic        w_access;
    logic        w_stall;
    logic        w_timeout;
    logic        w_flush;
    logic        w_wb_regwrite;
    logic [31:0] w_load_data;

    assign w_ex_capture = '{
        valid:      1'b1,
        alu_result: EX_ALU_result,
        zero:       EX_zero,
        rd:         EX_rd,
        branch:     EX_branch,
        memread:    EX_memread,
        memtoreg:   EX_memtoreg,
        memwrite:   EX_memwrite,
        regwrite:   EX_regwrite,
        uncond_jmp: EX_unconditional_jmp,
        rs2_data:   EX_rs2_data,
        pc:         EX_pc
    };

    assign w_memop = r_ex_mem.valid & (r_ex_mem.memread | r_ex_mem.memwrite);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned   = w_memop & (r_ex_mem.alu_result[1:0] != 2'b00);
    assign MEM_misaligned = w_misaligned;
`else
    assign w_misaligned   = 1'b0;
`endif

    assign w_access = w_memop & ~w_misaligned;

    mem_bus_fsm u_bus (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_access    (w_access),
        .i_ready     (dmem_ready),
        .o_req       (dmem_req),
        .o_stall     (w_stall),
        .o_timeout   (w_timeout),
        .o_bus_error (MEM_bus_error)
    );

    // A stall blocks the flush; the branch stays in EX/MEM and flushes once the stall clears.
    assign w_flush = r_ex_mem.valid & ~w_stall &
                     (r_ex_mem.uncond_jmp | (r_ex_mem.branch & r_ex_mem.zero));

    // EX/MEM register: hold on stall, bubble on EX stall or flush, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_mem <= EX_MEM_BUBBLE;
        end else if (!w_stall) begin
            if (EX_stall || w_flush) begin
                r_ex_mem <= EX_MEM_BUBBLE;
            end else begin
                r_ex_mem <= w_ex_capture;
            end
        end
    end

    // Stores, misaligned traps and writes to x0 never reach the register file.
    assign w_wb_regwrite = r_ex_mem.valid & r_ex_mem.regwrite & ~r_ex_mem.memwrite &
                           ~w_misaligned & (r_ex_mem.rd != 5'd0);
    assign w_load_data   = w_timeout ? 32'd0 : dmem_rdata;

    // MEM/WB register: advance when not stalled, otherwise emit a non-writing bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_rd       <= 5'd0;
            r_wb_regwrite <= 1'b0;
            r_wb_result   <= 32'd0;
        end else if (w_stall) begin
            r_wb_regwrite <= 1'b0;
        end else begin
            r_wb_rd       <= r_ex_mem.rd;
            r_wb_regwrite <= w_wb_regwrite;
            r_wb_result   <= r_ex_mem.memtoreg ? w_load_data : r_ex_mem.alu_result;
        end
    end

    assign EX_MEM_ALU_result = r_ex_mem.alu_result;
    assign EX_MEM_rd         = r_ex_mem.rd;
    assign EX_MEM_regwrite   = r_ex_mem.regwrite;
    assign EX_MEM_memread    = r_ex_mem.memread;
    assign EX_MEM_memtoreg   = r_ex_mem.memtoreg;
    assign MEM_WB_rd         = r_wb_rd;
    assign MEM_WB_regwrite   = r_wb_regwrite;
    assign MEM_WB_result     = r_wb_result;
    assign MEM_stall         = w_stall;
    assign MEM_flush         = w_flush;
    assign MEM_redirect_pc   = r_ex_mem.pc;
    assign dmem_we           = w_access & r_ex_mem.memwrite;
    assign dmem_addr         = r_ex_mem.alu_result;
    assign dmem_wdata        = r_ex_mem.rs2_data;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: instruction-level reference model of the MEM stage; the bench plays the
// EX stage and the data memory, and checks every MEM-stage output each cycle.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] EX_ALU_result, EX_rs2_data, EX_pc;
    logic        EX_zero, EX_branch, EX_memread, EX_memtoreg, EX_memwrite;
    logic        EX_regwrite, EX_unconditional_jmp, EX_stall;
    logic [4:0]  EX_rd;
    logic [31:0] EX_MEM_ALU_result, MEM_WB_result, MEM_redirect_pc;
    logic [4:0]  EX_MEM_rd, MEM_WB_rd;
    logic        EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memtoreg, MEM_WB_regwrite;
    logic        MEM_stall, MEM_flush, dmem_req, dmem_we, dmem_ready, MEM_bus_error;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .EX_ALU_result(EX_ALU_result), .EX_zero(EX_zero), .EX_rd(EX_rd),
        .EX_branch(EX_branch), .EX_memread(EX_memread), .EX_memtoreg(EX_memtoreg),
        .EX_memwrite(EX_memwrite), .EX_regwrite(EX_regwrite),
        .EX_unconditional_jmp(EX_unconditional_jmp), .EX_rs2_data(EX_rs2_data),
        .EX_pc(EX_pc), .EX_stall(EX_stall),
        .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rd(EX_MEM_rd),
        .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memread(EX_MEM_memread),
        .EX_MEM_memtoreg(EX_MEM_memtoreg), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_result(MEM_WB_result),
        .MEM_stall(MEM_stall), .MEM_flush(MEM_flush), .MEM_redirect_pc(MEM_redirect_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .MEM_bus_error(MEM_bus_error)
    );

    always #5 clk = ~clk;

    // One instruction as seen by the MEM stage, plus its memory latency and
    // how many EX-stall bubbles precede it.
    typedef struct {
        logic [31:0] alu, rs2, pc, rdata;
        logic [4:0]  rd;
        logic        zero, br, mr, mtr, mw, rw, uj;
        int          lat;
        int          pre_stall;
    } ins_t;

    ins_t        prog[$];
    ins_t        mins;
    bit          mvalid;
    int          k;
    bit          berr_exp;
    bit          exp_wb_rw;
    logic [4:0]  exp_wb_rd;
    logic [31:0] exp_wb_res;
    int          stall_pct;
    int          obs_stall, obs_flush, obs_wb;
    int          checks = 0;
    int          errors = 0;

    localparam int TMO = 16;

    function automatic ins_t mk(int kind, logic [4:0] rd, logic [31:0] a, logic [31:0] rs2,
                                logic [31:0] pc, logic zero, logic st_rw, int lat,
                                logic [31:0] rdata, int pre);
        ins_t x;
        x.alu = a; x.rs2 = rs2; x.pc = pc; x.rdata = rdata; x.rd = rd; x.zero = zero;
        x.br = 0; x.mr = 0; x.mtr = 0; x.mw = 0; x.rw = 0; x.uj = 0;
        x.lat = lat; x.pre_stall = pre;
        case (kind)
            0: x.rw = 1;
            1: begin x.mr = 1; x.mtr = 1; x.rw = 1; x.alu = a & 32'hFFFF_FFFC; end
            2: begin x.mw = 1; x.rw = st_rw; x.alu = a & 32'hFFFF_FFFC; end
            3: x.br = 1;
            default: begin x.uj = 1; x.rw = 1; end
        endcase
        return x;
    endfunction

    task automatic drive_ex(ins_t x, bit present, bit st);
        EX_ALU_result = present ? x.alu : 32'd0;
        EX_rs2_data   = present ? x.rs2 : 32'd0;
        EX_pc         = present ? x.pc  : 32'd0;
        EX_rd         = present ? x.rd  : 5'd0;
        EX_zero       = present & x.zero;
        EX_branch     = present & x.br;
        EX_memread    = present & x.mr;
        EX_memtoreg   = present & x.mtr;
        EX_memwrite   = present & x.mw;
        EX_regwrite   = present & x.rw;
        EX_unconditional_jmp = present & x.uj;
        EX_stall      = st;
    endtask

    task automatic model_reset();
        mvalid = 0; k = 0; berr_exp = 0; exp_wb_rw = 0; exp_wb_rd = 0; exp_wb_res = 0;
        obs_stall = 0; obs_flush = 0; obs_wb = 0;
    endtask

    task automatic do_reset();
        ins_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0; drive_ex(z, 0, 1); dmem_ready = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    // One clock cycle of the reference pipeline; entered and left at posedge+1.
    task automatic step();
        bit present, ex_st, m_mem, rdy, e_tmo, e_stall, e_flush;
        logic [31:0] rdat;
        ins_t head, tmp;
        present = prog.size() > 0;
        if (present) head = prog[0];
        else head = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_st = !present || head.pre_stall > 0 || ($urandom_range(0, 99) < stall_pct);
        drive_ex(head, present, ex_st);
        m_mem   = mvalid && (mins.mr || mins.mw);
        rdy     = m_mem && (k == mins.lat);
        e_tmo   = m_mem && (k == TMO) && !rdy;
        e_stall = m_mem && !rdy && !e_tmo;
        e_flush = mvalid && !e_stall && (mins.uj || (mins.br && mins.zero));
        rdat    = rdy ? mins.rdata : $urandom;
        dmem_ready = rdy;
        dmem_rdata = rdat;
        @(negedge clk);
        obs_stall += int'(MEM_stall);
        obs_flush += int'(MEM_flush);
        obs_wb    += int'(MEM_WB_regwrite);
        checks++;
        if (MEM_stall !== e_stall) begin errors++;
            $display("FAIL stall t=%0t got %b want %b", $time, MEM_stall, e_stall); end
        checks++;
        if (MEM_flush !== e_flush) begin errors++;
            $display("FAIL flush t=%0t got %b want %b", $time, MEM_flush, e_flush); end
        if (e_flush) begin
            checks++;
            if (MEM_redirect_pc !== mins.pc) begin errors++;
                $display("FAIL redirect_pc got %h want %h", MEM_redirect_pc, mins.pc); end
        end
        checks++;
        if (dmem_req !== m_mem) begin errors++;
            $display("FAIL dmem_req t=%0t got %b want %b", $time, dmem_req, m_mem); end
        if (m_mem) begin
            checks++;
            if (dmem_addr !== mins.alu || dmem_we !== mins.mw ||
                (mins.mw && dmem_wdata !== mins.rs2)) begin errors++;
                $display("FAIL dmem_bus got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                         dmem_addr, dmem_we, dmem_wdata, mins.alu, mins.mw, mins.rs2); end
        end
        checks++;
        if (EX_MEM_regwrite !== (mvalid && mins.rw) || EX_MEM_rd !== (mvalid ? mins.rd : 5'd0) ||
            EX_MEM_memread !== (mvalid && mins.mr) || EX_MEM_memtoreg !== (mvalid && mins.mtr) ||
            (mvalid && EX_MEM_ALU_result !== mins.alu)) begin errors++;
            $display("FAIL ex_mem t=%0t got rw=%b rd=%0d mr=%b res=%h want rw=%b rd=%0d mr=%b res=%h",
                     $time, EX_MEM_regwrite, EX_MEM_rd, EX_MEM_memread, EX_MEM_ALU_result,
                     mvalid && mins.rw, mvalid ? mins.rd : 5'd0, mvalid && mins.mr, mins.alu); end
        checks++;
        if (MEM_WB_regwrite !== exp_wb_rw ||
            (exp_wb_rw && (MEM_WB_rd !== exp_wb_rd || MEM_WB_result !== exp_wb_res))) begin errors++;
            $display("FAIL mem_wb t=%0t got rw=%b rd=%0d res=%h want rw=%b rd=%0d res=%h",
                     $time, MEM_WB_regwrite, MEM_WB_rd, MEM_WB_result, exp_wb_rw, exp_wb_rd, exp_wb_res); end
        checks++;
        if (MEM_bus_error !== berr_exp) begin errors++;
            $display("FAIL bus_error t=%0t got %b want %b", $time, MEM_bus_error, berr_exp); end
        // Advance the reference pipeline by one clock.
        if (e_tmo) berr_exp = 1;
        if (e_stall) begin
            exp_wb_rw = 0;
            k++;
        end else begin
            exp_wb_rw  = mvalid && mins.rw && !mins.mw && mins.rd != 0;
            exp_wb_rd  = mins.rd;
            exp_wb_res = mins.mtr ? (e_tmo ? 32'd0 : mins.rdata) : mins.alu;
            k = 0;
            if (e_flush) begin
                mvalid = 0;
                if (present && !ex_st) void'(prog.pop_front());
            end else if (ex_st) begin
                mvalid = 0;
                if (present && head.pre_stall > 0) begin
                    tmp = prog[0]; tmp.pre_stall--; prog[0] = tmp;
                end
            end else begin
                mins = prog.pop_front();
                mvalid = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(bit with_reset);
        int n = 0;
        if (with_reset) do_reset();
        while ((prog.size() > 0 || mvalid) && n < 5000) begin step(); n++; end
        repeat (2) step();
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL run_budget cycles=%0d limit=5000", n); end
    endtask

    task automatic test_reset();
        rst_n = 0; dmem_ready = 0; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (EX_MEM_ALU_result !== 0 || EX_MEM_rd !== 0 || EX_MEM_regwrite !== 0 ||
            EX_MEM_memread !== 0 || EX_MEM_memtoreg !== 0) begin errors++;
            $display("FAIL reset_ex_mem got res=%h rd=%0d rw=%b want 0", EX_MEM_ALU_result, EX_MEM_rd, EX_MEM_regwrite); end
        checks++;
        if (MEM_WB_rd !== 0 || MEM_WB_regwrite !== 0 || MEM_WB_result !== 0) begin errors++;
            $display("FAIL reset_mem_wb got rd=%0d rw=%b res=%h want 0", MEM_WB_rd, MEM_WB_regwrite, MEM_WB_result); end
        checks++;
        if (dmem_req !== 0 || MEM_stall !== 0 || MEM_flush !== 0 || MEM_bus_error !== 0) begin errors++;
            $display("FAIL reset_ctrl got req=%b stall=%b flush=%b berr=%b want 0", dmem_req, MEM_stall, MEM_flush, MEM_bus_error); end
        $display("reset: outputs checked during reset");
    endtask

    task automatic test_load_zero_wait();
        stall_pct = 0;
        prog.push_back(mk(1, 5, 32'h40, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0));
        run_prog(1);
        checks++;
        if (obs_stall !== 0 || obs_wb !== 1) begin errors++;
            $display("FAIL load_zero_wait got stalls=%0d wb=%0d want 0 and 1", obs_stall, obs_wb); end
        $display("load x5 @0x40 zero-wait: stalls=%0d wb=%0d", obs_stall, obs_wb);
    endtask

    task automatic test_store_wait();
        stall_pct = 0;
        prog.push_back(mk(2, 6, 32'h80, 32'h12345678, 0, 0, 1, 3, 0, 0));
        run_prog(1);
        checks++;
        if (obs_stall !== 3 || obs_wb !== 0) begin errors++;
            $display("FAIL store_wait got stalls=%0d wb=%0d want 3 and 0", obs_stall, obs_wb); end
        $display("store 0x12345678 @0x80 lat=3: stalls=%0d", obs_stall);
    endtask

    task automatic test_branch();
        stall_pct = 0;
        prog.push_back(mk(3, 0, 0, 0, 32'h100, 1, 0, 0, 0, 0));
        prog.push_back(mk(0, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(3, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 8, 32'h88, 0, 0, 0, 0, 0, 0, 0));
        run_prog(1);
        checks++;
        if (obs_flush !== 1 || obs_wb !== 1) begin errors++;
            $display("FAIL branch got flushes=%0d wb=%0d want 1 and 1", obs_flush, obs_wb); end
        $display("branch taken/not-taken: flushes=%0d", obs_flush);
    endtask

    task automatic test_timeout();
        stall_pct = 0;
        prog.push_back(mk(1, 9, 32'h44, 0, 0, 0, 0, 255, 32'h5555AAAA, 0));
        prog.push_back(mk(0, 10, 32'h1234, 0, 0, 0, 0, 0, 0, 0));
        run_prog(1);
        checks++;
        if (obs_stall !== TMO || MEM_bus_error !== 1'b1) begin errors++;
            $display("FAIL timeout got stalls=%0d berr=%b want %0d and 1", obs_stall, MEM_bus_error, TMO); end
        $display("load never ready: stalls=%0d bus_error=%b", obs_stall, MEM_bus_error);
    endtask

    task automatic test_rd0_exstall();
        stall_pct = 0;
        prog.push_back(mk(0, 0, 32'hABCD, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 9, 32'h99, 0, 0, 0, 0, 0, 0, 2));
        prog.push_back(mk(4, 11, 32'h44, 0, 32'h300, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 12, 32'h55, 0, 0, 0, 0, 0, 0, 0));
        run_prog(1);
        checks++;
        if (obs_wb !== 2 || obs_flush !== 1) begin errors++;
            $display("FAIL rd0_exstall got wb=%0d flushes=%0d want 2 and 1", obs_wb, obs_flush); end
        $display("rd=0 / EX_stall / jump: wb=%0d", obs_wb);
    endtask

    task automatic test_reset_mid_wait();
        ins_t ld;
        stall_pct = 0;
        do_reset();
        ld = mk(1, 3, 32'h40, 0, 0, 0, 0, 255, 0, 0);
        drive_ex(ld, 1, 0);
        @(posedge clk); #1;
        EX_stall = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || MEM_stall !== 1'b1) begin errors++;
            $display("FAIL mid_wait_active got req=%b stall=%b want 1 1", dmem_req, MEM_stall); end
        #2 rst_n = 0;
        #1;
        checks++;
        if (dmem_req !== 0 || MEM_stall !== 0 || EX_MEM_rd !== 0 || EX_MEM_memread !== 0 ||
            MEM_WB_regwrite !== 0 || MEM_bus_error !== 0) begin errors++;
            $display("FAIL mid_wait_reset got req=%b stall=%b rd=%0d mr=%b wb=%b berr=%b want 0",
                     dmem_req, MEM_stall, EX_MEM_rd, EX_MEM_memread, MEM_WB_regwrite, MEM_bus_error); end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        prog.push_back(mk(1, 4, 32'h48, 0, 0, 0, 0, 2, 32'hCAFEF00D, 0));
        prog.push_back(mk(1, 5, 32'h4C, 0, 0, 0, 0, 0, 32'h0BADF00D, 0));
        run_prog(0);
        checks++;
        if (obs_stall !== 2 || obs_wb !== 2) begin errors++;
            $display("FAIL after_reset got stalls=%0d wb=%0d want 2 and 2", obs_stall, obs_wb); end
        $display("reset during WAIT: req dropped, post-reset loads stalls=%0d", obs_stall);
    endtask

    task automatic test_random();
        int r, lat;
        stall_pct = 15;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) lat = 0;
            else if (r < 16) lat = r - 7;
            else if (r == 16) lat = 15;
            else if (r == 17) lat = 16;
            else if (r == 18) lat = 255;
            else lat = 2;
            prog.push_back(mk($urandom_range(0, 4), 5'($urandom_range(0, 31)), $urandom, $urandom,
                              $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              lat, $urandom, 0));
        end
        run_prog(1);
        $display("random: 200 instructions, stalls=%0d flushes=%0d wb=%0d", obs_stall, obs_flush, obs_wb);
    endtask

    initial begin
        rst_n = 0;
        stall_pct = 0;
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_branch();
        test_timeout();
        test_rd0_exstall();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX stage output interface: owns the EX/MEM pipeline register, the data-memory request/ready handshake, branch resolution and the MEM/WB pipeline register.
- Its EX_MEM_* and MEM_WB_* outputs are the forwarding sources the EX hazard checker reads back.
- Sits between the EX stage and the register-file write port.

Parameters:
- ALU_OP_NOPE, 4'd9, NOPE encoding; must match the EX stage.
- TIMEOUT, 8'd16, maximum wait cycles for dmem_ready before a bus error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- EX_ALU_result  in  32  ALU result / memory address
- EX_zero  in  1  ALU zero flag
- EX_rd  in  5  destination register
- EX_branch, EX_memread, EX_memtoreg, EX_memwrite, EX_regwrite, EX_unconditional_jmp  in  1 each  control bits
- EX_rs2_data  in  32  forwarded store data
- EX_pc  in  32  resolved branch/jump target
- EX_stall  in  1  load-use stall from EX; insert bubble
- EX_MEM_ALU_result  out  32  registered result
- EX_MEM_rd  out  5  registered destination
- EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memtoreg  out  1 each  registered controls
- MEM_WB_rd  out  5  writeback destination
- MEM_WB_regwrite  out  1  writeback enable
- MEM_WB_result  out  32  writeback data (load data or ALU result)
- MEM_stall  out  1  freeze IF/ID/EX and the EX/MEM register
- MEM_flush  out  1  squash the younger pipeline stages
- MEM_redirect_pc  out  32  fetch redirect target
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address (EX_MEM_ALU_result)
- dmem_wdata  out  32  store data
- dmem_ready  in  1  access complete
- dmem_rdata  in  32  load data
- MEM_bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): all EX_MEM_* and MEM_WB_* outputs 0, valid bits 0, FSM IDLE, timeout counter 0, MEM_bus_error 0. Reset mid-access drops dmem_req immediately.
- EX/MEM register:
  - Holds its value while MEM_stall=1.
  - Else captures a bubble (all control bits 0, valid 0) when EX_stall=1 or MEM_flush=1.
  - Otherwise captures all EX_* inputs with valid=1.
- FSM states:
  - IDLE: dmem_req = valid & (memread|memwrite). dmem_ready same cycle means zero-wait completion. Otherwise go to WAIT.
  - WAIT: dmem_req held, address/data/we stable. Counter increments each cycle. On dmem_ready, return to IDLE. On counter == TIMEOUT-1, set MEM_bus_error, complete with load data 0, return to IDLE.
- MEM_stall = dmem_req & ~dmem_ready & ~timeout-completion.
- MEM/WB register:
  - Updates every cycle MEM_stall=0; inserts a bubble (regwrite=0) while MEM_stall=1.
  - MEM_WB_result = memtoreg ? dmem_rdata : EX_MEM_ALU_result.
  - MEM_WB_regwrite forced 0 when rd==0.
- Branch resolution:
  - MEM_flush = valid & ~MEM_stall & (unconditional_jmp | (branch & zero)).
  - Pulses exactly one cycle; MEM_redirect_pc = EX_MEM pc.
  - Flush and stall together: stall wins, flush deferred until the stall ends.
- Store: dmem_we=1, dmem_wdata=EX_MEM rs2_data; MEM_WB_regwrite=0 regardless of the regwrite bit.
- Latency: EX output to MEM_WB is 2 cycles with zero-wait memory, plus N wait cycles.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A mem op with addr[1:0]!=0 issues no dmem_req.
  - Completes in 1 cycle with regwrite suppressed.
  - Pulses output MEM_misaligned for 1 cycle.
- Undefined: no MEM_misaligned port; addr[1:0] ignored, access issued as-is.

Decomposition:
- Shared package: ALU op constants, FSM state encoding (IDLE=0, WAIT=1), pipeline-register bubble constant.
- One natural sub-module: mem_bus_fsm (handshake FSM + timeout counter) producing dmem_req, MEM_stall, completion and bus-error signals.

Test Plan:
- Load x5 from addr 0x40, dmem_ready same cycle, rdata 0xDEADBEEF -> no stall; MEM_WB_rd=5, MEM_WB_result=0xDEADBEEF, regwrite=1 two cycles after EX.
- Store 0x12345678 to 0x80, ready after 3 cycles -> MEM_stall high 3 cycles; dmem_addr/we/wdata stable; MEM_WB_regwrite=0.
- Branch with EX_zero=1, EX_pc=0x100 -> MEM_flush one cycle, MEM_redirect_pc=0x100; next EX/MEM is a bubble. Same branch with zero=0 -> no flush.
- Load with dmem_ready never asserted, TIMEOUT=16 -> stall exactly 16 cycles, MEM_bus_error=1 sticky, MEM_WB_result=0.
- ALU op with rd=0, regwrite=1 -> MEM_WB_regwrite=0. EX_stall=1 -> EX_MEM_regwrite=0 the next cycle.
- rst_n low during WAIT -> dmem_req=0 immediately; all outputs 0; FSM IDLE after release.
